// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side packer.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_RATIO = 4;

  function automatic int lane_cnt_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  // Lane-valid mask with the lowest n lanes set.
  function automatic logic [31:0] keep_mask(input logic [31:0] n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/fifo_pack_flush_timer.sv
// Idle counter for the packer: pulses flush once the partial word has sat idle
// for FLUSH_CYCLES consecutive cycles. Only built with FIFO_PACK_FLUSH_EN.
module fifo_pack_flush_timer #(
  parameter int FLUSH_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  output logic flush
);

  localparam int IW = $clog2(FLUSH_CYCLES + 1);

  logic [IW-1:0] idle_cnt;

  // Saturates so a flush waiting on a busy output slot stays armed.
  always_ff @(posedge clk) begin
    if (rst || !idle) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IW'(FLUSH_CYCLES)) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  assign flush = (idle_cnt == IW'(FLUSH_CYCLES));

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains the async FIFO read port and packs RATIO entries per output word.
// Optional idle flush of partial words: define FIFO_PACK_FLUSH_EN.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int RATIO        = DEF_RATIO,
  parameter int OUT_W        = WIDTH * RATIO,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  input  logic             fifo_rd_err_i,
  output logic             fifo_rd_en_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [OUT_W-1:0] m_data_o,
  output logic [RATIO-1:0] m_keep_o,
  output logic             err_o
);

  localparam int CW = lane_cnt_w(RATIO);

  logic [CW-1:0]    cnt, cnt_n;
  logic             pend;
  logic [OUT_W-1:0] acc, acc_n;
  logic             slot_free;
  logic             full_move;
  logic             flush_move;
  logic             word_move;

  // Output port: a word transfers on m_valid_o && m_ready_i; while valid is
  // high without ready, data and keep hold; the slot frees on the transfer cycle.
  assign slot_free = !m_valid_o || m_ready_i;
  assign full_move = (cnt == CW'(RATIO)) && slot_free;

`ifdef FIFO_PACK_FLUSH_EN
  logic flush;

  fifo_pack_flush_timer #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush_timer (
    .clk  (clk_i),
    .rst  (rst_i),
    .idle ((cnt != '0) && !pend && fifo_empty_i),
    .flush(flush)
  );

  assign flush_move = flush && slot_free && (cnt != '0) && !full_move;
`else
  // Without the timer a partial word waits for its remaining entries.
  assign flush_move = (FLUSH_CYCLES < 0);
`endif

  assign word_move = full_move || flush_move;

  // An in-flight read is counted so the accumulator can never overflow.
  assign fifo_rd_en_o = !rst_i && !fifo_empty_i &&
                        ((int'(cnt) + int'(pend)) < RATIO) && !flush_move;

  always_comb begin
    acc_n = word_move ? '0 : acc;
    cnt_n = word_move ? '0 : cnt;
    if (pend) begin
      for (int k = 0; k < RATIO; k++) begin
        if (cnt_n == CW'(k)) begin
          acc_n[k*WIDTH +: WIDTH] = fifo_rdata_i;
        end
      end
      cnt_n = cnt_n + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt       <= '0;
      pend      <= 1'b0;
      acc       <= '0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_keep_o  <= '0;
      err_o     <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      acc  <= acc_n;
      pend <= fifo_rd_en_o;
      if (fifo_rd_err_i) begin
        err_o <= 1'b1;
      end
      if (word_move) begin
        m_data_o  <= acc;
        m_keep_o  <= RATIO'(keep_mask(32'(cnt)));
        m_valid_o <= 1'b1;
      end else if (m_ready_i) begin
        m_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Randomized and directed bench for fifo_rd_packer with a 1-cycle FIFO model
// and a stream-level packing reference (optional flush: FIFO_PACK_FLUSH_EN).
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        fifo_empty_i;
  logic [7:0]  fifo_rdata_i;
  logic        fifo_rd_err_i;
  logic        fifo_rd_en_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [31:0] m_data_o;
  logic [3:0]  m_keep_o;
  logic        err_o;

  fifo_rd_packer dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rd_err_i(fifo_rd_err_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_keep_o     (m_keep_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  fifo_q[$];
  logic [7:0]  part_q[$];
  logic [31:0] exp_q[$];
  logic [3:0]  exp_keep_q[$];
  int          rd_count   = 0;
  int          xfer_count = 0;
  logic        err_model  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [7:0] v);
    fifo_q.push_back(v);
    fifo_empty_i = 1'b0;
  endtask

  // Reference: entries enter the packer in FIFO order; every 4 form a word, first in LSB.
  task automatic model_enter(input logic [7:0] v);
    part_q.push_back(v);
    if (part_q.size() == 4) begin
      exp_q.push_back({part_q[3], part_q[2], part_q[1], part_q[0]});
      exp_keep_q.push_back(4'hF);
      part_q.delete();
    end
  endtask

  // One clock: caller has set inputs at the negedge; returns at the next negedge.
  task automatic tick();
    logic       pend_next;
    logic [7:0] val_next;
    logic       err_next;
    pend_next = 1'b0;
    val_next  = 8'h00;
    #1;
    if (!rst_i) begin
      check_eq("rd_when_empty", {31'b0, fifo_rd_en_o & fifo_empty_i}, 32'd0);
    end
    if (fifo_rd_en_o && fifo_q.size() > 0) begin
      val_next  = fifo_q.pop_front();
      pend_next = 1'b1;
      rd_count++;
      model_enter(val_next);
    end
    if (m_valid_o && m_ready_i && !rst_i && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      void'(exp_keep_q.pop_front());
      xfer_count++;
    end
    err_next = rst_i ? 1'b0 : (err_model | fifo_rd_err_i);
    if (rst_i) begin
      part_q.delete();
      exp_q.delete();
      exp_keep_q.delete();
    end
    @(posedge clk);
    @(negedge clk);
    err_model     = err_next;
    fifo_rdata_i  = pend_next ? val_next : 8'($urandom);
    fifo_empty_i  = (fifo_q.size() == 0);
    fifo_rd_err_i = 1'b0;
    check_eq("err_sticky", {31'b0, err_o}, {31'b0, err_model});
    if (m_valid_o) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", {31'b0, m_valid_o}, 32'd0);
      end else begin
        check_eq("word_data", m_data_o, exp_q[0]);
        check_eq("word_keep", {28'b0, m_keep_o}, {28'b0, exp_keep_q[0]});
      end
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int left;
    left = budget;
    tick();
    while (!m_valid_o && left > 0) begin
      tick();
      left--;
    end
    check_eq(tag, {31'b0, m_valid_o}, 32'd1);
  endtask

  initial begin
    int r0;
    int x0;
    int pushes;
    rst_i         = 1'b1;
    fifo_empty_i  = 1'b1;
    fifo_rdata_i  = 8'h00;
    fifo_rd_err_i = 1'b0;
    m_ready_i     = 1'b0;
    @(negedge clk);
    tick_n(2);
    check_eq("rst_valid", {31'b0, m_valid_o}, 32'd0);
    check_eq("rst_data", m_data_o, 32'd0);
    check_eq("rst_keep", {28'b0, m_keep_o}, 32'd0);
    check_eq("rst_err", {31'b0, err_o}, 32'd0);
    check_eq("rst_rd_en", {31'b0, fifo_rd_en_o}, 32'd0);
    rst_i = 1'b0;

    // Single word
    m_ready_i = 1'b1;
    r0 = rd_count;
    x0 = xfer_count;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_valid(20, "t1_valid_timeout");
    check_eq("t1_data", m_data_o, 32'h4433_2211);
    check_eq("t1_keep", {28'b0, m_keep_o}, 32'hF);
    tick_n(8);
    check_eq("t1_reads", rd_count - r0, 32'd4);
    check_eq("t1_words", xfer_count - x0, 32'd1);

    // Empty FIFO for 100 cycles
    r0 = rd_count;
    tick_n(100);
    check_eq("t2_valid", {31'b0, m_valid_o}, 32'd0);
    check_eq("t2_reads", rd_count - r0, 32'd0);

    // Back-pressure
    m_ready_i = 1'b0;
    r0 = rd_count;
    x0 = xfer_count;
    for (int i = 1; i <= 12; i++) push(8'(i));
    tick_n(40);
    check_eq("t3_stall_reads", rd_count - r0, 32'd8);
    check_eq("t3_held_valid", {31'b0, m_valid_o}, 32'd1);
    check_eq("t3_held_data", m_data_o, 32'h0403_0201);
    m_ready_i = 1'b1;
    tick_n(30);
    check_eq("t3_words", xfer_count - x0, 32'd3);
    check_eq("t3_reads", rd_count - r0, 32'd12);
    check_eq("t3_drained", exp_q.size(), 32'd0);

    // Error pulse
    fifo_rd_err_i = 1'b1;
    tick();
    tick_n(5);
    check_eq("t5_err", {31'b0, err_o}, 32'd1);
    push(8'h5A); push(8'h6B); push(8'h7C); push(8'h8D);
    wait_valid(20, "t5_valid_timeout");
    check_eq("t5_data", m_data_o, 32'h8D7C_6B5A);
    tick_n(4);

    // Reset mid-word
    push(8'hA1); push(8'hA2);
    tick_n(6);
    rst_i = 1'b1;
    tick();
    check_eq("t4_valid", {31'b0, m_valid_o}, 32'd0);
    check_eq("t4_data", m_data_o, 32'd0);
    check_eq("t4_keep", {28'b0, m_keep_o}, 32'd0);
    check_eq("t4_err", {31'b0, err_o}, 32'd0);
    check_eq("t4_rd_en", {31'b0, fifo_rd_en_o}, 32'd0);
    rst_i = 1'b0;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    wait_valid(20, "t4_valid_timeout");
    check_eq("t4_fresh_word", m_data_o, 32'hB4B3_B2B1);
    tick_n(4);

    // Random traffic, 48 entries (whole words), random back-pressure
    r0 = rd_count;
    x0 = xfer_count;
    pushes = 0;
    for (int c = 0; c < 600 && pushes < 48; c++) begin
      if ($urandom_range(1, 0) == 1) begin
        push(8'($urandom));
        pushes++;
      end
      m_ready_i = ($urandom_range(3, 0) != 0);
      if ($urandom_range(63, 0) == 0) fifo_rd_err_i = 1'b1;
      tick();
      check_eq("storage_bound", {31'b0, ((rd_count - r0) - 4 * (xfer_count - x0)) <= 8}, 32'd1);
    end
    m_ready_i = 1'b1;
    tick_n(40);
    check_eq("rand_pushes", pushes, 32'd48);
    check_eq("rand_words", xfer_count - x0, 32'd12);
    check_eq("rand_exp_empty", exp_q.size(), 32'd0);
    check_eq("rand_fifo_empty", fifo_q.size(), 32'd0);

    // Partial word with the FIFO left empty
    x0 = xfer_count;
    push(8'hAA); push(8'hBB);
    tick_n(60);
    check_eq("t6_hold", {31'b0, m_valid_o}, 32'd0);
`ifdef FIFO_PACK_FLUSH_EN
    part_q.delete();
    exp_q.push_back(32'h0000_BBAA);
    exp_keep_q.push_back(4'h3);
    wait_valid(40, "t6_flush_timeout");
    check_eq("t6_flush_data", m_data_o, 32'h0000_BBAA);
    check_eq("t6_flush_keep", {28'b0, m_keep_o}, 32'h3);
    tick_n(6);
    check_eq("t6_words", xfer_count - x0, 32'd1);
`else
    tick_n(40);
    check_eq("t6_still_held", {31'b0, m_valid_o}, 32'd0);
    push(8'hCC); push(8'hDD);
    wait_valid(20, "t6_valid_timeout");
    check_eq("t6_data", m_data_o, 32'hDDCC_BBAA);
    check_eq("t6_keep", {28'b0, m_keep_o}, 32'hF);
    tick_n(6);
    check_eq("t6_words", xfer_count - x0, 32'd1);
`endif
    check_eq("final_exp_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
